// File: rtl/ram_banked_clr.sv
// ram_banked_clr
//   Parametrised single-port synchronous RAM with a registered read path.
//   After reset, an optional clear sweep writes zero to every word.
//   While the sweep runs, busy is high and access requests are dropped.
//
// Parameters
//   DATA_WIDTH      word width in bits
//   ADDR_WIDTH      address bits; DEPTH = 2**ADDR_WIDTH words
//   CLEAR_ON_RESET  1: zero all words after reset; 0: no sweep, contents undefined
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   enable        access request; ignored while busy
//   write_enable  1 = write, 0 = read; qualified by enable
//   addr          word address
//   dados_in      write data
//   dados_out     registered read data; holds its last value
//   dados_valid   one-cycle pulse after each accepted read
//   busy          clear sweep in progress
module ram_banked_clr #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dados_in,
  output logic [DATA_WIDTH-1:0] dados_out,
  output logic                  dados_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clear_ptr;
  logic [ADDR_WIDTH-1:0] w_clear_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_dados_out;
  logic                  r_dados_valid;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_rd_en;

  // Next-state and port-sharing logic. The sweep and user writes share the
  // single write port; the sweep owns it for the whole CLEAR state.
  always_comb begin
    w_state_nxt     = r_state;
    w_clear_ptr_nxt = r_clear_ptr;
    w_mem_we        = 1'b0;
    w_mem_addr      = addr;
    w_mem_wdata     = dados_in;
    w_rd_en         = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        w_mem_we        = 1'b1;
        w_mem_addr      = r_clear_ptr;
        w_mem_wdata     = '0;
        w_clear_ptr_nxt = r_clear_ptr + 1'b1;
        // DEPTH is a power of two, so the last word is the all-ones address.
        if (r_clear_ptr == '1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (enable) begin
          if (write_enable) begin
            w_mem_we = 1'b1;
          end else begin
            w_rd_en = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_clear_ptr   <= '0;
      r_dados_out   <= '0;
      r_dados_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_clear_ptr   <= w_clear_ptr_nxt;
      r_dados_valid <= w_rd_en;
      if (w_rd_en) begin
        r_dados_out <= r_mem[addr];
      end
    end
  end

  // Storage is not reset; a write is suppressed on a reset edge so that a
  // reset arriving mid-sweep or mid-access leaves no partial side effect.
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign dados_out   = r_dados_out;
  assign dados_valid = r_dados_valid;
  assign busy        = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_banked_clr.sv
module tb_ram_banked_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        write_enable;
  logic [3:0]  addr;
  logic [15:0] din;

  logic [7:0]  dout0;
  logic        valid0, busy0;
  logic [15:0] dout1;
  logic        valid1, busy1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_banked_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .write_enable(write_enable),
    .addr(addr[1:0]), .dados_in(din[7:0]),
    .dados_out(dout0), .dados_valid(valid0), .busy(busy0)
  );

  ram_banked_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .write_enable(write_enable),
    .addr(addr), .dados_in(din),
    .dados_out(dout1), .dados_valid(valid1), .busy(busy1)
  );

  // Reference model: memory contents, remaining busy cycles, held output.
  logic [15:0] m_mem [2][16];
  int          m_busy_left [2];
  logic [15:0] m_out [2];
  bit          m_valid [2];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  bit          chk_on = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit en, input bit we,
                            input logic [3:0] a, input logic [15:0] dt);
    for (int d = 0; d < 2; d++) begin
      int          dep = (d == 0) ? 4 : 16;
      logic [15:0] dm  = (d == 0) ? 16'h00FF : 16'hFFFF;
      int          ai  = (d == 0) ? int'(a[1:0]) : int'(a);
      if (r) begin
        m_busy_left[d] = dep;
        m_out[d]       = '0;
        m_valid[d]     = 1'b0;
      end else if (m_busy_left[d] > 0) begin
        m_busy_left[d]--;
        m_valid[d] = 1'b0;
        if (m_busy_left[d] == 0)
          for (int k = 0; k < 16; k++) m_mem[d][k] = '0;
      end else if (en && we) begin
        m_mem[d][ai] = dt & dm;
        m_valid[d]   = 1'b0;
      end else if (en) begin
        m_out[d]   = m_mem[d][ai];
        m_valid[d] = 1'b1;
        if (d == 0) q0.push_back(m_out[d]);
        else        q1.push_back(m_out[d]);
      end else begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit en, input bit we,
                     input logic [3:0] a, input logic [15:0] dt);
    reset = r; enable = en; write_enable = we; addr = a; din = dt;
    @(posedge clk);
    model_edge(r, en, we, a, dt);
    if (r) chk_on = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'($urandom), 16'($urandom));
  endtask

  // Monitor: compares visible outputs with the model and pops the scoreboard
  // whenever a DUT presents read data.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy0", {15'd0, busy0}, {15'd0, m_busy_left[0] > 0});
      check("busy1", {15'd0, busy1}, {15'd0, m_busy_left[1] > 0});
      check("valid0", {15'd0, valid0}, {15'd0, m_valid[0]});
      check("valid1", {15'd0, valid1}, {15'd0, m_valid[1]});
      check("hold0", {8'd0, dout0}, m_out[0]);
      check("hold1", dout1, m_out[1]);
      if (valid0 === 1'b1) begin
        if (q0.size() == 0) check("q0_underflow", 16'd1, 16'd0);
        else check("read0", {8'd0, dout0}, q0.pop_front());
      end
      if (valid1 === 1'b1) begin
        if (q1.size() == 0) check("q1_underflow", 16'd1, 16'd0);
        else check("read1", dout1, q1.pop_front());
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) m_mem[d][k] = '0;
      m_busy_left[d] = 0; m_out[d] = '0; m_valid[d] = 1'b0;
    end
    reset = 1'b0; enable = 1'b0; write_enable = 1'b0; addr = '0; din = '0;
    @(posedge clk); #1;

    // 1) reset, full sweep, read every word of the small RAM
    cyc(1, 0, 0, 0, 0);
    idle(16);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'(i), 0);
    idle(1);

    // 2) writes then back-to-back reads
    cyc(0, 1, 1, 1, 16'h00A5);
    cyc(0, 1, 1, 2, 16'h003C);
    cyc(0, 1, 0, 2, 0);
    cyc(0, 1, 0, 1, 0);
    idle(2);

    // 3) write during busy is dropped
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 16'h005A);
    idle(16);
    cyc(0, 1, 0, 3, 0);
    idle(1);

    // 4) write then immediate read, then hold while enable=0
    cyc(0, 1, 1, 0, 16'h00FF);
    cyc(0, 1, 0, 0, 0);
    idle(3);

    // 5) reset again at the second sweep cycle
    cyc(0, 1, 1, 3, 16'h0011);
    cyc(1, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0);
    idle(16);
    cyc(0, 1, 0, 3, 0);
    idle(1);

    // 6) wide-configuration corner addresses
    cyc(0, 1, 1, 15, 16'hBEEF);
    cyc(0, 1, 0, 15, 0);
    cyc(0, 1, 1, 0, 16'h1234);
    cyc(0, 1, 0, 0, 0);
    idle(2);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1) == 1, 4'($urandom), 16'($urandom));
    end
    idle(3);

    check("q0_drained", 16'(q0.size()), 16'd0);
    check("q1_drained", 16'(q1.size()), 16'd0);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
